// File: rtl/mc_9999.sv
// Single-accumulator micro-controller core: one instruction per clk, strobe-timed sleep, two simple-I/O pins.
// Optional feature macro: MC9999_MUL_EN enables the saturating multiply (opcode 4); otherwise opcode 4 is a NOP.

module mc_9999_imem #(
    parameter int IMEM_DEPTH = 16,
    parameter int IW         = 32,
    parameter int AW         = 4
) (
    input  logic          clk,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [IW-1:0] ld_data,
    input  logic [AW-1:0] addr,
    output logic [IW-1:0] data
);
    logic [IW-1:0] memory [0:IMEM_DEPTH-1];

    // Contents come from a memory-image preload or this load port; reset never touches them.
    always_ff @(posedge clk) begin
        if (ld_en) memory[ld_addr] <= ld_data;
    end

    assign data = memory[addr];
endmodule

module mc_9999 #(
    parameter int IMEM_DEPTH = 16,
    parameter int IW         = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        posedge_big_clk,
    input  logic [10:0] p0_in,
    input  logic [10:0] p1_in,
    output logic [10:0] p0_out,
    output logic [10:0] p1_out
);
    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
`ifdef MC9999_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd4;
`endif
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_TEQ = 4'd6;
    localparam logic [3:0] OP_TGT = 4'd7;
    localparam logic [3:0] OP_TLT = 4'd8;
    localparam logic [3:0] OP_TCP = 4'd9;
    localparam logic [3:0] OP_SLP = 4'd10;

    typedef enum logic {S_RUN, S_SLEEP} state_t;

    state_t               state;
    logic [AW-1:0]        program_counter;
    logic [AW-1:0]        pc_next;
    logic [IW-1:0]        final_instruction;
    logic signed [10:0]   acc;
    logic signed [10:0]   dat;
    logic                 flag_pos;
    logic                 flag_neg;
    logic [9:0]           sleep_cnt;

    logic [1:0]           cond;
    logic [3:0]           opcode;
    logic [1:0]           a_type;
    logic [1:0]           b_type;
    logic signed [10:0]   a_val;
    logic signed [10:0]   b_val;
    logic signed [10:0]   a_op;
    logic signed [10:0]   b_op;
    logic                 cond_ok;
    logic signed [12:0]   add_sum;
    logic signed [12:0]   sub_diff;
`ifdef MC9999_MUL_EN
    logic signed [21:0]   mul_prod;
`endif

    mc_9999_imem #(
        .IMEM_DEPTH(IMEM_DEPTH),
        .IW        (IW),
        .AW        (AW)
    ) instructionMemory (
        .clk    (clk),
        .ld_en  (1'b0),
        .ld_addr('0),
        .ld_data('0),
        .addr   (program_counter),
        .data   (final_instruction)
    );

    assign cond   = final_instruction[31:30];
    assign opcode = final_instruction[29:26];
    assign a_type = final_instruction[25:24];
    assign a_val  = final_instruction[23:13];
    assign b_type = final_instruction[12:11];
    assign b_val  = final_instruction[10:0];

    always_comb begin
        a_op = a_val;
        case (a_type)
            2'b01:   a_op = acc;
            2'b10:   a_op = dat;
            2'b11:   a_op = a_val[0] ? p1_in : p0_in;
            default: a_op = a_val;
        endcase
    end

    always_comb begin
        b_op = b_val;
        case (b_type)
            2'b01:   b_op = acc;
            2'b10:   b_op = dat;
            2'b11:   b_op = b_val[0] ? p1_in : p0_in;
            default: b_op = b_val;
        endcase
    end

    // A cleared flag (neither + nor -) makes every conditional line skip.
    always_comb begin
        case (cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = flag_pos;
            2'b10:   cond_ok = flag_neg;
            default: cond_ok = 1'b0;
        endcase
    end

    assign pc_next  = (program_counter == AW'(IMEM_DEPTH - 1)) ? '0 : program_counter + 1'b1;
    assign add_sum  = 13'(acc) + 13'(a_op);
    assign sub_diff = 13'(acc) - 13'(a_op);
`ifdef MC9999_MUL_EN
    assign mul_prod = 22'(acc) * 22'(a_op);
`endif

    function automatic logic signed [10:0] sat(input logic signed [21:0] v);
        if (v > 22'sd999)       return 11'sd999;
        else if (v < -22'sd999) return -11'sd999;
        else                    return v[10:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_RUN;
            program_counter <= '0;
            acc             <= '0;
            dat             <= '0;
            flag_pos        <= 1'b0;
            flag_neg        <= 1'b0;
            sleep_cnt       <= '0;
            p0_out          <= '0;
            p1_out          <= '0;
        end else begin
            case (state)
                S_SLEEP: begin
                    if (posedge_big_clk) begin
                        if (sleep_cnt == 10'd1) begin
                            sleep_cnt <= '0;
                            state     <= S_RUN;
                        end else begin
                            sleep_cnt <= sleep_cnt - 10'd1;
                        end
                    end
                end
                default: begin
                    program_counter <= pc_next;
                    if (cond_ok) begin
                        case (opcode)
                            OP_MOV: begin
                                case (b_type)
                                    2'b01: acc <= a_op;
                                    2'b10: dat <= a_op;
                                    2'b11: begin
                                        if (b_val[0]) p1_out <= a_op;
                                        else          p0_out <= a_op;
                                    end
                                    default: ;
                                endcase
                            end
                            OP_ADD: acc <= sat(22'(add_sum));
                            OP_SUB: acc <= sat(22'(sub_diff));
`ifdef MC9999_MUL_EN
                            OP_MUL: acc <= sat(mul_prod);
`endif
                            OP_NOT: acc <= (acc == '0) ? 11'sd100 : 11'sd0;
                            OP_TEQ: begin
                                flag_pos <= (a_op == b_op);
                                flag_neg <= (a_op != b_op);
                            end
                            OP_TGT: begin
                                flag_pos <= (a_op > b_op);
                                flag_neg <= !(a_op > b_op);
                            end
                            OP_TLT: begin
                                flag_pos <= (a_op < b_op);
                                flag_neg <= !(a_op < b_op);
                            end
                            OP_TCP: begin
                                if (a_op > b_op) begin
                                    flag_pos <= 1'b1;
                                    flag_neg <= 1'b0;
                                end else if (a_op < b_op) begin
                                    flag_pos <= 1'b0;
                                    flag_neg <= 1'b1;
                                end
                            end
                            OP_SLP: begin
                                // Strobe on this edge is deliberately not counted.
                                if (a_op > 11'sd0) begin
                                    sleep_cnt <= a_op[9:0];
                                    state     <= S_SLEEP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mc_9999.sv
// Scoreboard bench for mc_9999: an ISA-level model predicts pc/acc/dat/pins each cycle, a monitor compares.
module tb_mc_9999;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               posedge_big_clk = 1'b0;
    logic signed [10:0] p0_in = '0;
    logic signed [10:0] p1_in = '0;
    logic [10:0]        p0_out;
    logic [10:0]        p1_out;

    always #5 clk = ~clk;

    mc_9999 #(.IMEM_DEPTH(DEPTH), .IW(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .posedge_big_clk(posedge_big_clk),
        .p0_in          (p0_in),
        .p1_in          (p1_in),
        .p0_out         (p0_out),
        .p1_out         (p1_out)
    );

    typedef struct {
        int pc;
        int acc;
        int dat;
        int p0;
        int p1;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [31:0] prog [DEPTH];
    int m_pc, m_acc, m_dat, m_p0, m_p1, m_flag, m_sleep;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 999)  return 999;
        if (v < -999) return -999;
        return v;
    endfunction

    function automatic int opnd(input int t, input logic [10:0] v, input int p0, input int p1);
        case (t)
            1:       return m_acc;
            2:       return m_dat;
            3:       return v[0] ? p1 : p0;
            default: return int'($signed(v));
        endcase
    endfunction

    function automatic logic [31:0] mk(input int c, input int op, input int at, input int av,
                                       input int bt, input int bv);
        return {2'(c), 4'(op), 2'(at), 11'(av), 2'(bt), 11'(bv)};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_acc = 0; m_dat = 0; m_p0 = 0; m_p1 = 0; m_flag = 0; m_sleep = 0;
    endtask

    // Flag: 0 none, 1 plus, 2 minus.
    task automatic model_step(input bit strobe, input int p0, input int p1);
        logic [31:0] w;
        int a, b, c;
        if (m_sleep > 0) begin
            if (strobe) m_sleep--;
            return;
        end
        w = prog[m_pc];
        m_pc = (m_pc + 1) % DEPTH;
        c = int'(w[31:30]);
        if (c == 3 || (c == 1 && m_flag != 1) || (c == 2 && m_flag != 2)) return;
        a = opnd(int'(w[25:24]), w[23:13], p0, p1);
        b = opnd(int'(w[12:11]), w[10:0], p0, p1);
        case (int'(w[29:26]))
            1: case (int'(w[12:11]))
                   1: m_acc = a;
                   2: m_dat = a;
                   3: if (w[0]) m_p1 = a; else m_p0 = a;
                   default: ;
               endcase
            2: m_acc = sat(m_acc + a);
            3: m_acc = sat(m_acc - a);
`ifdef MC9999_MUL_EN
            4: m_acc = sat(m_acc * a);
`endif
            5: m_acc = (m_acc == 0) ? 100 : 0;
            6: m_flag = (a == b) ? 1 : 2;
            7: m_flag = (a > b) ? 1 : 2;
            8: m_flag = (a < b) ? 1 : 2;
            9: if (a > b) m_flag = 1; else if (a < b) m_flag = 2;
            10: if (a > 0) m_sleep = a;
            default: ;
        endcase
    endtask

    task automatic cycle(input bit rst, input bit strobe, input int p0, input int p1);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        posedge_big_clk = strobe;
        p0_in = 11'(p0);
        p1_in = 11'(p1);
        if (!rst) begin
            model_reset();
            #1;
            chk("async_rst_pc", int'(dut.program_counter), 0);
            chk("async_rst_p0", int'($signed(p0_out)), 0);
            chk("async_rst_p1", int'($signed(p1_out)), 0);
        end else begin
            model_step(strobe, int'(p0_in), int'(p1_in));
        end
        e.pc = m_pc; e.acc = m_acc; e.dat = m_dat; e.p0 = m_p0; e.p1 = m_p1;
        q.push_back(e);
    endtask

    task automatic reset_load();
        cycle(1'b0, 1'b0, 0, 0);
        for (int i = 0; i < DEPTH; i++) dut.instructionMemory.memory[i] = prog[i];
        cycle(1'b0, 1'b0, 0, 0);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    endtask

    task automatic run(input int n, input int p0, input int p1);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, p0, p1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_pc",  int'(dut.program_counter), e.pc);
                chk("sb_acc", int'(dut.acc), e.acc);
                chk("sb_dat", int'(dut.dat), e.dat);
                chk("sb_p0",  int'($signed(p0_out)), e.p0);
                chk("sb_p1",  int'($signed(p1_out)), e.p1);
            end
        end
    end

    initial begin : stim
        // MOV 50->p0; SLP 1
        clear_prog();
        prog[0] = mk(0, 1, 0, 50, 3, 0);
        prog[1] = mk(0, 10, 0, 1, 0, 0);
        reset_load();
        run(1, 0, 0);
        settle();
        chk("slp1_p0_cycle1", int'($signed(p0_out)), 50);
        run(4, 0, 0);
        settle();
        chk("slp1_pc_hold", int'(dut.program_counter), 2);
        cycle(1'b1, 1'b1, 0, 0);
        cycle(1'b1, 1'b0, 0, 0);
        settle();
        chk("slp1_resume_pc", int'(dut.program_counter), 3);

        // Saturation high, then low
        clear_prog();
        prog[0] = mk(0, 1, 0, 600, 1, 0);
        prog[1] = mk(0, 2, 0, 600, 0, 0);
        prog[2] = mk(0, 1, 1, 0, 3, 1);
        reset_load();
        run(4, 0, 0);
        settle();
        chk("sat_hi_p1", int'($signed(p1_out)), 999);
        prog[0] = mk(0, 1, 0, -600, 1, 0);
        prog[1] = mk(0, 3, 0, 1000, 0, 0);
        reset_load();
        run(3, 0, 0);
        settle();
        chk("sat_lo_acc", int'(dut.acc), -999);

        // Conditional execution from TEQ on a pin
        clear_prog();
        prog[0] = mk(0, 6, 3, 0, 0, 5);
        prog[1] = mk(1, 1, 0, 1, 3, 1);
        prog[2] = mk(2, 1, 0, 2, 3, 1);
        reset_load();
        run(4, 5, 0);
        settle();
        chk("teq_eq_p1", int'($signed(p1_out)), 1);
        reset_load();
        run(4, 6, 0);
        settle();
        chk("teq_ne_p1", int'($signed(p1_out)), 2);

        // SLP 3 with a strobe on the issue edge
        clear_prog();
        prog[0] = mk(0, 10, 0, 3, 0, 0);
        prog[1] = mk(0, 1, 0, 7, 3, 0);
        reset_load();
        cycle(1'b1, 1'b1, 0, 0);
        cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b1, 1'b1, 0, 0);
        cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b1, 1'b1, 0, 0);
        cycle(1'b1, 1'b1, 0, 0);
        settle();
        chk("slp3_hold_pc", int'(dut.program_counter), 1);
        chk("slp3_hold_p0", int'($signed(p0_out)), 0);
        cycle(1'b1, 1'b0, 0, 0);
        settle();
        chk("slp3_resume_p0", int'($signed(p0_out)), 7);

        // Mid-program reset clears flag; also covers PC wrap
        clear_prog();
        prog[0] = mk(1, 1, 0, 9, 3, 0);
        prog[1] = mk(0, 6, 0, 1, 0, 1);
        prog[2] = mk(1, 1, 0, 8, 3, 1);
        reset_load();
        run(DEPTH + 2, 0, 0);
        settle();
        chk("wrap_p0", int'($signed(p0_out)), 9);
        cycle(1'b0, 1'b0, 0, 0);
        run(1, 0, 0);
        settle();
        chk("rst_flag_skip_p0", int'($signed(p0_out)), 0);

        // MUL
        clear_prog();
        prog[0] = mk(0, 1, 0, 3, 1, 0);
        prog[1] = mk(0, 4, 0, 4, 0, 0);
        reset_load();
        run(3, 0, 0);
        settle();
`ifdef MC9999_MUL_EN
        chk("mul_acc", int'(dut.acc), 12);
`else
        chk("mul_acc", int'(dut.acc), 3);
`endif

        // Randomized programs, strobes, pins and occasional reset
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int c, op, at, av;
                c  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                op = int'($urandom_range(0, 15));
                at = int'($urandom_range(0, 3));
                av = int'($urandom_range(0, 2047));
                if (op == 10) begin
                    at = 0;
                    av = int'($urandom_range(0, 5)) - 2;
                end
                prog[i] = mk(c, op, at, av, int'($urandom_range(0, 3)), int'($urandom_range(0, 2047)));
            end
            reset_load();
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(0, 99) == 0)
                    cycle(1'b0, 1'b0, 0, 0);
                else
                    cycle(1'b1, $urandom_range(0, 2) == 0,
                          int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
            end
        end

        settle();
        settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
